// File: rtl/vga_frota_carregador.sv
// vga_frota_carregador
// Collects ship cells from the game FSM over a valid/ready handshake and
// assembles each ship into the 64-bit position vector used by its VGA
// renderer. Finished ships are committed in one step, so a renderer never
// sees a half-updated ship.
//
// Optional feature macro: VGA_FROTA_SYNC_VBLANK_EN
//   defined     -> a finished ship waits for the falling edge of areaAtiva
//                  (start of blanking) before it is committed
//   not defined -> a finished ship is committed right away; areaAtiva is ignored
module vga_frota_carregador #(
    parameter int TAM_NAVIO0 = 5,
    parameter int TAM_NAVIO1 = 4,
    parameter int TAM_NAVIO2 = 3,
    parameter int TAM_NAVIO3 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        areaAtiva,
    input  logic        cel_valid,
    output logic        cel_ready,
    input  logic [1:0]  cel_navio,
    input  logic [3:0]  cel_x,
    input  logic [3:0]  cel_y,
    input  logic        cel_ultima,
    output logic [63:0] pos_navio0,
    output logic [63:0] pos_navio1,
    output logic [63:0] pos_navio2,
    output logic [63:0] pos_navio3,
    output logic        atualizado,
    output logic        erro
);

    typedef enum logic [2:0] {
        IDLE,
        COLETA,
        ESPERA_VBLANK,
        COMMIT,
        DESCARTA
    } estado_t;

    estado_t     estado;
    estado_t     estadoProx;
    logic [3:0]  shadowX [5];
    logic [3:0]  shadowY [5];
    logic [2:0]  cnt;
    logic [1:0]  id;
    logic        bad;
    logic        areaAtiva_d;

    logic        aceita;
    logic        foraFaixa;
    logic [1:0]  idAtual;
    logic [2:0]  tamAtual;
    logic [2:0]  cntBase;
    logic [2:0]  cntProx;
    logic        badProx;
    logic        fimTransacao;
    logic [63:0] vetorCommit;

    function automatic logic [2:0] tamDe(input logic [1:0] navio);
        case (navio)
            2'd0:    tamDe = 3'(TAM_NAVIO0);
            2'd1:    tamDe = 3'(TAM_NAVIO1);
            2'd2:    tamDe = 3'(TAM_NAVIO2);
            default: tamDe = 3'(TAM_NAVIO3);
        endcase
    endfunction

`ifndef VGA_FROTA_SYNC_VBLANK_EN
    // Without blanking sync the edge register has no reader; this net keeps
    // it referenced so it is not reported as dead logic.
    logic unusedBordaVblank;
    assign unusedBordaVblank = areaAtiva_d;
`endif

    // Per-cell bookkeeping: on the first cell the ship id comes from the bus,
    // later cells use the latched id so a mid-transaction id change is ignored.
    always_comb begin
        aceita       = cel_valid && cel_ready;
        foraFaixa    = (cel_x == 4'd0) || (cel_x > 4'd8) ||
                       (cel_y == 4'd0) || (cel_y > 4'd8);
        idAtual      = (estado == IDLE) ? cel_navio : id;
        tamAtual     = tamDe(idAtual);
        cntBase      = (estado == IDLE) ? 3'd0 : cnt;
        cntProx      = cntBase + 3'd1;
        badProx      = (estado == IDLE) ? foraFaixa : (bad || foraFaixa);
        fimTransacao = cel_ultima || (cntProx == tamAtual);
    end

    // Next-state logic and handshake ready; ready is only high while collecting.
    always_comb begin
        estadoProx = estado;
        cel_ready  = 1'b0;
        case (estado)
            IDLE, COLETA: begin
                cel_ready = 1'b1;
                if (aceita) begin
                    if (fimTransacao) begin
                        if (badProx || (cntProx != tamAtual)) begin
                            estadoProx = DESCARTA;
                        end else begin
`ifdef VGA_FROTA_SYNC_VBLANK_EN
                            estadoProx = ESPERA_VBLANK;
`else
                            estadoProx = COMMIT;
`endif
                        end
                    end else begin
                        estadoProx = COLETA;
                    end
                end
            end
            ESPERA_VBLANK: begin
`ifdef VGA_FROTA_SYNC_VBLANK_EN
                if (areaAtiva_d && !areaAtiva) begin
                    estadoProx = COMMIT;
                end
`else
                estadoProx = COMMIT;
`endif
            end
            COMMIT:   estadoProx = IDLE;
            DESCARTA: estadoProx = IDLE;
            default:  estadoProx = IDLE;
        endcase
    end

    // Packs the shadow buffer into renderer format; cells beyond the ship's
    // size are forced to zero so stale data can never leak into a vector.
    always_comb begin
        vetorCommit = '0;
        for (int k = 0; k < 5; k++) begin
            if (3'(k) < tamDe(id)) begin
                vetorCommit[6 + 8*k -: 4]  = shadowX[k];
                vetorCommit[10 + 8*k -: 4] = shadowY[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estadoProx;
        end
    end

    // Shadow buffer, edge detector, committed vectors and the event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 5; k++) begin
                shadowX[k] <= '0;
                shadowY[k] <= '0;
            end
            cnt         <= '0;
            id          <= '0;
            bad         <= 1'b0;
            areaAtiva_d <= 1'b0;
            pos_navio0  <= '0;
            pos_navio1  <= '0;
            pos_navio2  <= '0;
            pos_navio3  <= '0;
            atualizado  <= 1'b0;
            erro        <= 1'b0;
        end else begin
            areaAtiva_d <= areaAtiva;
            atualizado  <= 1'b0;
            erro        <= 1'b0;
            case (estado)
                IDLE, COLETA: begin
                    if (aceita) begin
                        if (estado == IDLE) begin
                            id <= cel_navio;
                        end
                        if (cntBase < 3'd5) begin
                            shadowX[cntBase] <= cel_x;
                            shadowY[cntBase] <= cel_y;
                        end
                        cnt <= cntProx;
                        bad <= badProx;
                    end
                end
                COMMIT: begin
                    case (id)
                        2'd0:    pos_navio0 <= vetorCommit;
                        2'd1:    pos_navio1 <= vetorCommit;
                        2'd2:    pos_navio2 <= vetorCommit;
                        default: pos_navio3 <= vetorCommit;
                    endcase
                    atualizado <= 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        shadowX[k] <= '0;
                        shadowY[k] <= '0;
                    end
                    cnt <= '0;
                    bad <= 1'b0;
                end
                DESCARTA: begin
                    erro <= 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        shadowX[k] <= '0;
                        shadowY[k] <= '0;
                    end
                    cnt <= '0;
                    bad <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frota_carregador.sv
// Testbench for vga_frota_carregador: directed ships, scoreboard of expected
// commit/error events checked by an independent monitor on the falling edge.
module tb_vga_frota_carregador;

    logic        clk = 1'b0;
    logic        rst;
    logic        areaAtiva;
    logic        cel_valid;
    logic        cel_ready;
    logic [1:0]  cel_navio;
    logic [3:0]  cel_x;
    logic [3:0]  cel_y;
    logic        cel_ultima;
    logic [63:0] pos_navio0;
    logic [63:0] pos_navio1;
    logic [63:0] pos_navio2;
    logic [63:0] pos_navio3;
    logic        atualizado;
    logic        erro;

    typedef struct {
        bit          ehErro;
        int          navio;
        logic [63:0] valor;
        int          ciclo;
    } evento_t;

    evento_t     fila[$];
    logic [63:0] expPos [4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lastAccept = 0;

    vga_frota_carregador dut (
        .clk        (clk),
        .rst        (rst),
        .areaAtiva  (areaAtiva),
        .cel_valid  (cel_valid),
        .cel_ready  (cel_ready),
        .cel_navio  (cel_navio),
        .cel_x      (cel_x),
        .cel_y      (cel_y),
        .cel_ultima (cel_ultima),
        .pos_navio0 (pos_navio0),
        .pos_navio1 (pos_navio1),
        .pos_navio2 (pos_navio2),
        .pos_navio3 (pos_navio3),
        .atualizado (atualizado),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to time the expected events.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pk(input int k, input logic [3:0] x, input logic [3:0] y);
        logic [63:0] v;
        v = '0;
        v[6 + 8*k -: 4]  = x;
        v[10 + 8*k -: 4] = y;
        return v;
    endfunction

    function automatic logic [63:0] posDut(input int i);
        case (i)
            0:       return pos_navio0;
            1:       return pos_navio1;
            2:       return pos_navio2;
            default: return pos_navio3;
        endcase
    endfunction

    task automatic checkOutput(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    task automatic checkAllPos(input string etapa);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s pos_navio%0d", etapa, i), posDut(i), expPos[i]);
        end
    endtask

    // Offer one cell and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [1:0] n, input logic [3:0] x, input logic [3:0] y, input logic u);
        int t = 0;
        @(negedge clk);
        cel_valid  = 1'b1;
        cel_navio  = n;
        cel_x      = x;
        cel_y      = y;
        cel_ultima = u;
        while (!cel_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cel_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake timeout: cel_ready got 0 expected 1");
        end
        lastAccept = cyc + 1;
        @(posedge clk);
        #1;
        cel_valid  = 1'b0;
        cel_ultima = 1'b0;
    endtask

    // Queue a commit of ship n right after its last accepted cell.
    task automatic expectCommit(input int n, input logic [63:0] v);
        evento_t e;
        e.ehErro = 1'b0;
        e.navio  = n;
        e.valor  = v;
`ifdef VGA_FROTA_SYNC_VBLANK_EN
        repeat (4) begin
            @(negedge clk);
            checkOutput("hold cel_ready", {63'd0, cel_ready}, 64'd0);
            checkOutput("hold atualizado", {63'd0, atualizado}, 64'd0);
        end
        areaAtiva = 1'b0;
        e.ciclo = cyc + 2;
        fila.push_back(e);
        @(negedge clk);
        areaAtiva = 1'b1;
`else
        e.ciclo = lastAccept + 1;
        fila.push_back(e);
`endif
    endtask

    task automatic expectErro();
        evento_t e;
        e.ehErro = 1'b1;
        e.navio  = 0;
        e.valor  = '0;
        e.ciclo  = lastAccept + 1;
        fila.push_back(e);
    endtask

    task automatic waitDrain();
        int t = 0;
        while (fila.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (fila.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL event timeout: pending got %0d expected 0", fila.size());
            fila.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops an expectation on every atualizado/erro pulse.
    initial begin
        evento_t e;
        forever begin
            @(negedge clk);
            if (!rst && (atualizado || erro)) begin
                if (fila.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected event: atualizado=%0d erro=%0d expected none", atualizado, erro);
                end else begin
                    e = fila.pop_front();
                    checkOutput("event atualizado", {63'd0, atualizado}, {63'd0, !e.ehErro});
                    checkOutput("event erro", {63'd0, erro}, {63'd0, e.ehErro});
                    checkOutput("event cycle", 64'(cyc), 64'(e.ciclo));
                    if (!e.ehErro) expPos[e.navio] = e.valor;
                    checkAllPos("event");
                end
            end
        end
    end

    initial begin
        logic [63:0] v;
        rst        = 1'b1;
        areaAtiva  = 1'b1;
        cel_valid  = 1'b0;
        cel_navio  = '0;
        cel_x      = '0;
        cel_y      = '0;
        cel_ultima = 1'b0;
        for (int i = 0; i < 4; i++) expPos[i] = '0;

        repeat (3) @(negedge clk);
        checkAllPos("reset");
        checkOutput("reset atualizado", {63'd0, atualizado}, 64'd0);
        checkOutput("reset erro", {63'd0, erro}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset cel_ready", {63'd0, cel_ready}, 64'd1);

        // Ship 3: (2,5),(3,5) ending on cel_ultima
        applyStimulus(2'd3, 4'd2, 4'd5, 1'b0);
        applyStimulus(2'd3, 4'd3, 4'd5, 1'b1);
        expectCommit(3, 64'h0000_0000_0002_9A90);
        waitDrain();

        // Ship 0: five cells, auto-end; id change on cell 3 must be ignored
        v = '0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus((k == 2) ? 2'd2 : 2'd0, 4'(k + 1), 4'd1, 1'b0);
            v |= pk(k, 4'(k + 1), 4'd1);
        end
        expectCommit(0, v);
        waitDrain();

        // Ship 1: x=9 among four cells -> rejected
        applyStimulus(2'd1, 4'd1, 4'd2, 1'b0);
        applyStimulus(2'd1, 4'd9, 4'd2, 1'b0);
        applyStimulus(2'd1, 4'd3, 4'd2, 1'b0);
        applyStimulus(2'd1, 4'd4, 4'd2, 1'b0);
        expectErro();
        waitDrain();
        checkOutput("after erro cel_ready", {63'd0, cel_ready}, 64'd1);

        // Ship 2: two cells with cel_ultima but size 3 -> rejected
        applyStimulus(2'd2, 4'd1, 4'd3, 1'b0);
        applyStimulus(2'd2, 4'd2, 4'd3, 1'b1);
        expectErro();
        waitDrain();

        // Reset with ships loaded clears every vector asynchronously
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) expPos[i] = '0;
        checkAllPos("async reset");
        checkOutput("async reset atualizado", {63'd0, atualizado}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post reset cel_ready", {63'd0, cel_ready}, 64'd1);

`ifdef VGA_FROTA_SYNC_VBLANK_EN
        // Reset while waiting for blanking: the following edge commits nothing
        applyStimulus(2'd3, 4'd4, 4'd4, 1'b0);
        applyStimulus(2'd3, 4'd5, 4'd4, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("espera reset pos_navio3", pos_navio3, 64'd0);
        checkOutput("espera reset cel_ready", {63'd0, cel_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        areaAtiva = 1'b0;
        @(negedge clk);
        areaAtiva = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no commit after reset", {63'd0, atualizado}, 64'd0);
        end
`endif

        // Ship 3 again with areaAtiva held high
        applyStimulus(2'd3, 4'd8, 4'd1, 1'b0);
        applyStimulus(2'd3, 4'd7, 4'd8, 1'b1);
        expectCommit(3, pk(0, 4'd8, 4'd1) | pk(1, 4'd7, 4'd8));
        waitDrain();
        checkAllPos("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
